// File: rtl/decoder_share_arbiter.sv
// ---------------------------------------------------------------------------
// decoder_share_arbiter
//
// Shares one 6x64 one-hot decoder between four requesters. Picks a winner
// among the asserted requests (round-robin by default), drives the decoder
// enable/address for DWELL cycles, and then holds the decoder idle for GAP
// cycles. Requests still pending after the gap are arbitrated on the next
// IDLE cycle. Because of that gap, two decoder outputs belonging to different
// requesters are never active in adjacent cycles.
//
// Build option:
//   DEC_ARB_FIXED_PRI_EN  when defined, the winner is the lowest-index
//                         asserted request (req[0] highest) and rr_ptr
//                         stays at 0. All timing is otherwise identical.
//
// Parameters:
//   DWELL  cycles dec_en stays high per grant (1..255)
//   GAP    idle cycles after each grant before the next arbitration (1..255)
//
// Ports:
//   clk       clock, rising edge
//   rst       asynchronous active-high reset
//   req       [3:0]  level requests, held until the matching done pulse
//   req_addr  [23:0] requester i address = req_addr[6*i+5:6*i]
//   gnt       [3:0]  one-hot grant, high for the whole window
//   dec_en           decoder enable (equals |gnt)
//   dec_a     [5:0]  decoder address, latched at grant
//   done      [3:0]  one-cycle pulse to the granted requester in the last
//                    dwell cycle
//   busy             high while a window or its gap is in progress
// ---------------------------------------------------------------------------
module decoder_share_arbiter #(
  parameter int DWELL = 4,
  parameter int GAP   = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  req,
  input  logic [23:0] req_addr,
  output logic [3:0]  gnt,
  output logic        dec_en,
  output logic [5:0]  dec_a,
  output logic [3:0]  done,
  output logic        busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  localparam logic [7:0] DWELL_LD = 8'(DWELL - 1);
  localparam logic [7:0] GAP_LD   = 8'(GAP - 1);

  state_t     state;
  logic [7:0] cnt;
  logic [1:0] rr_ptr;
  logic [1:0] win;

  // Address slice belonging to requester w.
  function automatic logic [5:0] addr_of(input logic [23:0] addrs,
                                         input logic [1:0]  w);
    return addrs[6*int'(w) +: 6];
  endfunction

  // Winner selection among the currently asserted requests.
`ifdef DEC_ARB_FIXED_PRI_EN
  always_comb begin
    win = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (req[i]) win = 2'(i);
    end
  end
`else
  // Scan rr_ptr, rr_ptr+1, ... with natural 2-bit wrap.
  always_comb begin
    logic       found;
    logic [1:0] idx;
    win   = rr_ptr;
    found = 1'b0;
    idx   = 2'd0;
    for (int i = 0; i < 4; i++) begin
      idx = rr_ptr + 2'(i);
      if (!found && req[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_IDLE;
      cnt    <= 8'd0;
      rr_ptr <= 2'd0;
      gnt    <= 4'd0;
      dec_en <= 1'b0;
      dec_a  <= 6'd0;
      done   <= 4'd0;
      busy   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 4'd0;
          if (|req) begin
            gnt    <= 4'b0001 << win;
            dec_en <= 1'b1;
            dec_a  <= addr_of(req_addr, win);
            busy   <= 1'b1;
            cnt    <= DWELL_LD;
            // A single-cycle window has its done pulse in the grant cycle.
            done   <= (DWELL == 1) ? (4'b0001 << win) : 4'd0;
`ifndef DEC_ARB_FIXED_PRI_EN
            rr_ptr <= win + 2'd1;
`endif
            state  <= ST_HOLD;
          end
        end

        ST_HOLD: begin
          // Address and grant are frozen; a dropped request still completes.
          if (cnt != 8'd0) begin
            cnt <= cnt - 8'd1;
            // done is registered, so raise it one edge ahead of the last cycle.
            if (cnt == 8'd1) done <= gnt;
          end else begin
            gnt    <= 4'd0;
            dec_en <= 1'b0;
            dec_a  <= 6'd0;
            done   <= 4'd0;
            cnt    <= GAP_LD;
            state  <= ST_GAP;
          end
        end

        ST_GAP: begin
          if (cnt != 8'd0) begin
            cnt <= cnt - 8'd1;
          end else begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_decoder_share_arbiter.sv
// ---------------------------------------------------------------------------
// tb_decoder_share_arbiter
//
// Two instances share one stimulus: instance 0 with DWELL=4/GAP=1 and
// instance 1 with DWELL=1/GAP=1. A window-schedule reference model predicts
// every output after every clock edge: each instance remembers the edge index
// at which its current window started, its owner, the latched address and the
// rotation pointer. All outputs follow from simple edge arithmetic relative
// to that start edge.
// ---------------------------------------------------------------------------
module tb_decoder_share_arbiter;

  localparam int DW [2] = '{4, 1};
  localparam int GP [2] = '{1, 1};

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [23:0] req_addr;

  logic [3:0]  gnt    [2];
  logic        dec_en [2];
  logic [5:0]  dec_a  [2];
  logic [3:0]  done   [2];
  logic        busy   [2];

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  decoder_share_arbiter #(.DWELL(4), .GAP(1)) dut0 (
    .clk(clk), .rst(rst), .req(req), .req_addr(req_addr),
    .gnt(gnt[0]), .dec_en(dec_en[0]), .dec_a(dec_a[0]),
    .done(done[0]), .busy(busy[0])
  );

  decoder_share_arbiter #(.DWELL(1), .GAP(1)) dut1 (
    .clk(clk), .rst(rst), .req(req), .req_addr(req_addr),
    .gnt(gnt[1]), .dec_en(dec_en[1]), .dec_a(dec_a[1]),
    .done(done[1]), .busy(busy[1])
  );

  // Reference model state
  int         e;          // index of the most recent clock edge
  int         s     [2];  // edge at which the current/last window started
  int         owner [2];
  logic [5:0] alat  [2];
  int         ptr   [2];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h (edge %0d)", tag, obs, exp, e);
    end
  endtask

  function automatic int pick(input logic [3:0] r, input int p);
`ifdef DEC_ARB_FIXED_PRI_EN
    for (int i = 0; i < 4; i++) if (r[i]) return i;
`else
    for (int i = 0; i < 4; i++) if (r[(p + i) % 4]) return (p + i) % 4;
`endif
    return -1;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      s[k] = -1000; owner[k] = 0; alat[k] = 6'd0; ptr[k] = 0;
    end
  endtask

  // Advance the model across the coming edge, using the inputs now applied.
  task automatic model_edge();
    int w;
    e++;
    for (int k = 0; k < 2; k++) begin
      if (e >= s[k] + DW[k] + GP[k] + 1 && req != 4'd0) begin
        w        = pick(req, ptr[k]);
        s[k]     = e;
        owner[k] = w;
        alat[k]  = req_addr[6*w +: 6];
`ifdef DEC_ARB_FIXED_PRI_EN
        ptr[k]   = 0;
`else
        ptr[k]   = (w + 1) % 4;
`endif
      end
    end
  endtask

  task automatic check_all();
    logic       in_win;
    logic [3:0] eg;
    for (int k = 0; k < 2; k++) begin
      in_win = (e >= s[k]) && (e <= s[k] + DW[k] - 1);
      eg     = in_win ? 4'(1 << owner[k]) : 4'd0;
      check($sformatf("gnt%0d", k),    gnt[k],    eg);
      check($sformatf("dec_en%0d", k), dec_en[k], in_win);
      check($sformatf("dec_a%0d", k),  dec_a[k],  in_win ? alat[k] : 6'd0);
      check($sformatf("done%0d", k),   done[k],   (e == s[k] + DW[k] - 1) ? eg : 4'd0);
      check($sformatf("busy%0d", k),   busy[k],
            (e >= s[k]) && (e <= s[k] + DW[k] + GP[k] - 1));
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  task automatic check_zero(input string tag);
    for (int k = 0; k < 2; k++) begin
      check($sformatf("%s_gnt%0d", tag, k),    gnt[k],    4'd0);
      check($sformatf("%s_dec_en%0d", tag, k), dec_en[k], 1'b0);
      check($sformatf("%s_dec_a%0d", tag, k),  dec_a[k],  6'd0);
      check($sformatf("%s_done%0d", tag, k),   done[k],   4'd0);
      check($sformatf("%s_busy%0d", tag, k),   busy[k],   1'b0);
    end
  endtask

  initial begin
    e = 0;
    model_reset();
    rst      = 1'b1;
    req      = 4'd0;
    req_addr = 24'd0;
    #2;
    check_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    // Single requester 0, address 37
    req_addr[5:0] = 6'd37;
    req = 4'b0001;
    step();
    check("t1_dec_a", dec_a[0], 6'd37);
    check("t1_decoder_y", 64'd1 << dec_a[0], 64'd1 << 37);
    req = 4'b0000;
    for (int i = 0; i < 6; i++) step();

    // All four requesting, addresses 10..13
    for (int i = 0; i < 4; i++) req_addr[6*i +: 6] = 6'(10 + i);
    req = 4'b1111;
    for (int i = 0; i < 32; i++) step();
    req = 4'b0000;
    for (int i = 0; i < 6; i++) step();

    // Requester 2 drops its request one cycle into the window
    req_addr[17:12] = 6'd50;
    req = 4'b0100;
    step();
    step();
    req = 4'b0000;
    for (int i = 0; i < 6; i++) step();

    // Asynchronous reset in the second HOLD cycle
    req = 4'b0001;
    step();
    step();
    #2;
    rst = 1'b1;
    #1;
    check_zero("async_rst");
    @(posedge clk);
    e++;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    req = 4'b1010;
    for (int i = 0; i < 8; i++) step();
    req = 4'b0110;
    for (int i = 0; i < 10; i++) step();

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0) req_addr = 24'($urandom);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
